// File: rtl/nes_cpu_pkg.sv
// Shared NES CPU core types and constants: address width, PC unit states, vector addresses.
// Pure declarations, no logic.
package nes_cpu_pkg;

    localparam int MEM_ADDR_SIZE = 16;

    localparam logic [15:0] RESET_VEC_ADDR = 16'hFFFC;
    localparam logic [15:0] NMI_VEC_ADDR   = 16'hFFFA;
    localparam logic [15:0] IRQ_VEC_ADDR   = 16'hFFFE;

    typedef logic [1:0] instr_len_t;

    typedef enum logic [1:0] {
        VEC_LO,
        VEC_HI,
        RUN,
        BR_FIX
    } pc_state_e;

endpackage

// File: rtl/pc_branch_calc.sv
// Relative branch target: sign-extends the 8-bit offset, adds it to the PC and flags a page change.
// Purely combinational, zero latency, no backpressure.
module pc_branch_calc #(
    parameter int ADDR_W = 16
) (
    input  logic [ADDR_W-1:0] pc_i,
    input  logic [7:0]        off_i,
    output logic [ADDR_W-1:0] sum_o,
    output logic              page_cross_o
);

    logic [ADDR_W-1:0] off_ext;

    always_comb begin
        off_ext      = {{(ADDR_W-8){off_i[7]}}, off_i};
        sum_o        = pc_i + off_ext;
        page_cross_o = (sum_o[ADDR_W-1:8] != pc_i[ADDR_W-1:8]);
    end

endmodule

// File: rtl/pc_unit.sv
// Program counter: variable-length increment, jumps, relative branches with page-cross fix-up, vector loads.
// One-cycle update latency; stall_i freezes RUN/BR_FIX, vector reads wait on mem_ack_i.
module pc_unit
    import nes_cpu_pkg::*;
#(
    parameter int                ADDR_W    = MEM_ADDR_SIZE,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(RESET_VEC_ADDR),
    parameter logic [ADDR_W-1:0] NMI_VEC   = ADDR_W'(NMI_VEC_ADDR),
    parameter logic [ADDR_W-1:0] IRQ_VEC   = ADDR_W'(IRQ_VEC_ADDR)
) (
    input  logic              clk_i,
    input  logic              rstn_i,
    input  logic              stall_i,
    input  logic              incr_i,
    input  logic [1:0]        instr_len_i,
    input  logic              jump_i,
    input  logic [ADDR_W-1:0] jump_pc_i,
    input  logic              branch_i,
    input  logic [7:0]        branch_off_i,
    input  logic              vec_req_i,
    input  logic              vec_sel_i,
    output logic              mem_req_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [7:0]        mem_rdata_i,
    input  logic              mem_ack_i,
    output logic [ADDR_W-1:0] pc_o,
    output logic              pc_valid_o,
    output logic              busy_o,
    output logic              page_cross_o
);

    pc_state_e         state_q, state_d;
    logic [ADDR_W-1:0] vec_addr_q, vec_addr_d;
    logic [7:0]        lo_q, lo_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              pc_valid_q, pc_valid_d;
    logic [ADDR_W-1:0] fix_pc_q, fix_pc_d;
    logic              page_cross_q, page_cross_d;

    logic [ADDR_W-1:0] br_sum;
    logic              br_cross;
    instr_len_t        len;

    pc_branch_calc #(.ADDR_W(ADDR_W)) u_branch_calc (
        .pc_i        (pc_q),
        .off_i       (branch_off_i),
        .sum_o       (br_sum),
        .page_cross_o(br_cross)
    );

    assign len = instr_len_i;

    always_comb begin
        state_d      = state_q;
        vec_addr_d   = vec_addr_q;
        lo_d         = lo_q;
        pc_d         = pc_q;
        pc_valid_d   = pc_valid_q;
        fix_pc_d     = fix_pc_q;
        page_cross_d = 1'b0;

        case (state_q)
            VEC_LO: begin
                if (mem_ack_i) begin
                    lo_d    = mem_rdata_i;
                    state_d = VEC_HI;
                end
            end
            VEC_HI: begin
                if (mem_ack_i) begin
                    pc_d       = ADDR_W'({mem_rdata_i, lo_q});
                    pc_valid_d = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                if (!stall_i) begin
                    if (vec_req_i) begin
                        vec_addr_d = vec_sel_i ? IRQ_VEC : NMI_VEC;
                        pc_valid_d = 1'b0;
                        state_d    = VEC_LO;
                    end else if (jump_i) begin
                        pc_d = jump_pc_i;
                    end else if (branch_i) begin
                        if (!br_cross) begin
                            pc_d = br_sum;
                        end else begin
                            // Low byte lands first, as on the 6502; the high byte is fixed next cycle.
                            pc_d         = {pc_q[ADDR_W-1:8], br_sum[7:0]};
                            fix_pc_d     = br_sum;
                            pc_valid_d   = 1'b0;
                            page_cross_d = 1'b1;
                            state_d      = BR_FIX;
                        end
                    end else if (incr_i) begin
                        pc_d = pc_q + ADDR_W'(len);
                    end
                end
            end
            BR_FIX: begin
                if (!stall_i) begin
                    pc_d       = fix_pc_q;
                    pc_valid_d = 1'b1;
                    state_d    = RUN;
                end
            end
            default: state_d = VEC_LO;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q      <= VEC_LO;
            vec_addr_q   <= RESET_VEC;
            lo_q         <= 8'h00;
            pc_q         <= '0;
            pc_valid_q   <= 1'b0;
            fix_pc_q     <= '0;
            page_cross_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            vec_addr_q   <= vec_addr_d;
            lo_q         <= lo_d;
            pc_q         <= pc_d;
            pc_valid_q   <= pc_valid_d;
            fix_pc_q     <= fix_pc_d;
            page_cross_q <= page_cross_d;
        end
    end

    assign mem_req_o    = (state_q == VEC_LO) || (state_q == VEC_HI);
    assign mem_addr_o   = (state_q == VEC_HI) ? vec_addr_q + ADDR_W'(1) : vec_addr_q;
    assign pc_o         = pc_q;
    assign pc_valid_o   = pc_valid_q;
    assign busy_o       = (state_q != RUN);
    assign page_cross_o = page_cross_q;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed scenarios with literal expectations, then randomized traffic vs a behavioural model.
module tb_pc_unit;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        stall_i, incr_i, jump_i, branch_i, vec_req_i, vec_sel_i, mem_ack_i;
    logic [1:0]  instr_len_i;
    logic [15:0] jump_pc_i;
    logic [7:0]  branch_off_i, mem_rdata_i;
    logic        mem_req_o, pc_valid_o, busy_o, page_cross_o;
    logic [15:0] mem_addr_o, pc_o;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Behavioural model state
    bit      m_loading;
    int      m_byte;
    int      m_vec_base;
    int      m_lo;
    int      m_pc;
    bit      m_valid;
    bit      m_pcross;
    bit      m_in_fix;
    int      m_fix_target;

    always #5 clk_i = ~clk_i;

    pc_unit dut (
        .clk_i       (clk_i),
        .rstn_i      (rstn_i),
        .stall_i     (stall_i),
        .incr_i      (incr_i),
        .instr_len_i (instr_len_i),
        .jump_i      (jump_i),
        .jump_pc_i   (jump_pc_i),
        .branch_i    (branch_i),
        .branch_off_i(branch_off_i),
        .vec_req_i   (vec_req_i),
        .vec_sel_i   (vec_sel_i),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i),
        .pc_o        (pc_o),
        .pc_valid_o  (pc_valid_o),
        .busy_o      (busy_o),
        .page_cross_o(page_cross_o)
    );

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_loading    = 1'b1;
        m_byte       = 0;
        m_vec_base   = 16'hFFFC;
        m_lo         = 0;
        m_pc         = 0;
        m_valid      = 1'b0;
        m_pcross     = 1'b0;
        m_in_fix     = 1'b0;
        m_fix_target = 0;
    endtask

    task automatic model_step();
        int off, target;
        m_pcross = 1'b0;
        if (m_loading) begin
            if (mem_ack_i) begin
                if (m_byte == 0) begin
                    m_lo   = mem_rdata_i;
                    m_byte = 1;
                end else begin
                    m_pc      = mem_rdata_i * 256 + m_lo;
                    m_valid   = 1'b1;
                    m_loading = 1'b0;
                end
            end
        end else if (m_in_fix) begin
            if (!stall_i) begin
                m_pc     = m_fix_target;
                m_valid  = 1'b1;
                m_in_fix = 1'b0;
            end
        end else if (!stall_i) begin
            if (vec_req_i) begin
                m_loading  = 1'b1;
                m_byte     = 0;
                m_vec_base = vec_sel_i ? 16'hFFFE : 16'hFFFA;
                m_valid    = 1'b0;
            end else if (jump_i) begin
                m_pc = jump_pc_i;
            end else if (branch_i) begin
                off    = (branch_off_i >= 128) ? int'(branch_off_i) - 256 : int'(branch_off_i);
                target = (m_pc + off + 65536) % 65536;
                if (target / 256 == m_pc / 256) begin
                    m_pc = target;
                end else begin
                    m_pc         = (m_pc / 256) * 256 + target % 256;
                    m_fix_target = target;
                    m_valid      = 1'b0;
                    m_pcross     = 1'b1;
                    m_in_fix     = 1'b1;
                end
            end else if (incr_i) begin
                m_pc = (m_pc + instr_len_i) % 65536;
            end
        end
    endtask

    // Compare process: every negedge, DUT outputs vs the model.
    always @(negedge clk_i) begin
        if (chk_en) begin
            check("pc_o", pc_o, m_pc);
            check("pc_valid_o", pc_valid_o, m_valid);
            check("busy_o", busy_o, m_loading || m_in_fix);
            check("page_cross_o", page_cross_o, m_pcross);
            check("mem_req_o", mem_req_o, m_loading);
            if (m_loading)
                check("mem_addr_o", mem_addr_o, (m_vec_base + m_byte) % 65536);
        end
    end

    task automatic idle();
        stall_i = 0; incr_i = 0; instr_len_i = 0; jump_i = 0; jump_pc_i = 0;
        branch_i = 0; branch_off_i = 0; vec_req_i = 0; vec_sel_i = 0;
        mem_ack_i = 0; mem_rdata_i = 0;
    endtask

    task automatic step();
        @(posedge clk_i);
        if (rstn_i) model_step();
        #1;
        idle();
    endtask

    task automatic reset_pulse();
        rstn_i = 1'b0;
        model_reset();
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
    endtask

    task automatic do_jump(input logic [15:0] a);
        jump_i = 1; jump_pc_i = a; step();
    endtask

    task automatic do_ack(input logic [7:0] d);
        mem_ack_i = 1; mem_rdata_i = d; step();
    endtask

    initial begin
        idle();
        rstn_i = 1'b0;
        model_reset();
        chk_en = 1'b1;
        #12;
        check("rst_addr", mem_addr_o, 16'hFFFC);
        check("rst_pc", pc_o, 16'h0000);
        rstn_i = 1'b1;

        // 1: reset vector fetch
        do_ack(8'h34);
        check("t1_addr_hi", mem_addr_o, 16'hFFFD);
        do_ack(8'h12);
        check("t1_pc", pc_o, 16'h1234);
        check("t1_valid", pc_valid_o, 1);

        // 2: increments and stall
        do_jump(16'h8000);
        incr_i = 1; instr_len_i = 1; step();
        check("t2_len1", pc_o, 16'h8001);
        incr_i = 1; instr_len_i = 2; step();
        incr_i = 1; instr_len_i = 3; step();
        check("t2_len3", pc_o, 16'h8006);
        stall_i = 1; incr_i = 1; instr_len_i = 3; step();
        stall_i = 1; incr_i = 1; instr_len_i = 3; step();
        check("t2_stall", pc_o, 16'h8006);

        // 3: branches
        do_jump(16'h80F0);
        branch_i = 1; branch_off_i = 8'h05; step();
        check("t3_same_page", pc_o, 16'h80F5);
        check("t3_no_cross", page_cross_o, 0);
        do_jump(16'h80F0);
        branch_i = 1; branch_off_i = 8'h20; step();
        check("t3_interim", pc_o, 16'h8010);
        check("t3_pcross", page_cross_o, 1);
        check("t3_invalid", pc_valid_o, 0);
        step();
        check("t3_fixed", pc_o, 16'h8110);
        check("t3_fix_valid", pc_valid_o, 1);

        // 4: wrap-around
        do_jump(16'hFFFF);
        incr_i = 1; instr_len_i = 1; step();
        check("t4_wrap", pc_o, 16'h0000);
        do_jump(16'h0010);
        branch_i = 1; branch_off_i = 8'hE0; step();
        check("t4_interim", pc_o, 16'h00F0);
        step();
        check("t4_fixed", pc_o, 16'hFFF0);

        // 5: priorities
        jump_i = 1; jump_pc_i = 16'h4000; branch_i = 1; branch_off_i = 8'h10; step();
        check("t5_jump_wins", pc_o, 16'h4000);
        vec_req_i = 1; vec_sel_i = 0; jump_i = 1; jump_pc_i = 16'h5555; step();
        check("t5_nmi_addr", mem_addr_o, 16'hFFFA);
        check("t5_pc_held", pc_o, 16'h4000);
        do_ack(8'h00);
        do_ack(8'hC0);
        check("t5_nmi_pc", pc_o, 16'hC000);

        // 6: reset during IRQ high-byte fetch
        vec_req_i = 1; vec_sel_i = 1; step();
        check("t6_irq_addr", mem_addr_o, 16'hFFFE);
        do_ack(8'h77);
        check("t6_irq_hi", mem_addr_o, 16'hFFFF);
        rstn_i = 1'b0;
        model_reset();
        #1;
        check("t6_rst_addr", mem_addr_o, 16'hFFFC);
        check("t6_rst_busy", busy_o, 1);
        @(posedge clk_i);
        #1;
        rstn_i = 1'b1;
        do_ack(8'h00);
        do_ack(8'h90);
        check("t6_boot_pc", pc_o, 16'h9000);

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(399) == 0) begin
                reset_pulse();
            end else begin
                stall_i      = ($urandom_range(7) == 0);
                incr_i       = $urandom_range(1);
                instr_len_i  = 2'($urandom_range(3));
                jump_i       = ($urandom_range(9) == 0);
                jump_pc_i    = 16'($urandom);
                branch_i     = ($urandom_range(5) == 0);
                branch_off_i = 8'($urandom);
                vec_req_i    = ($urandom_range(29) == 0);
                vec_sel_i    = $urandom_range(1);
                mem_ack_i    = m_loading ? ($urandom_range(2) != 0) : ($urandom_range(4) == 0);
                mem_rdata_i  = 8'($urandom);
                step();
            end
        end

        @(negedge clk_i);
        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_unit.md
Name: pc_unit

Overview:
- Next-generation program counter for the NES CPU core. Replaces the fixed-step PC with a parametrised unit.
- Supports variable instruction length (1–3 bytes), absolute jumps, and 6502-style signed relative branches with a page-cross fix-up cycle.
- Loads interrupt/reset vectors through a two-byte memory handshake.
- Sits between the decode/execute stage (redirect requests) and the fetch stage and memory arbiter (pc_o, vector reads).

Parameters:
- ADDR_W, 16, PC and memory address width; defaults to MEM_ADDR_SIZE.
- RESET_VEC, 16'hFFFC, address of the reset vector low byte.
- NMI_VEC, 16'hFFFA, address of the NMI vector low byte.
- IRQ_VEC, 16'hFFFE, address of the IRQ/BRK vector low byte.

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  asynchronous active-low reset
- stall_i  in  1  freeze PC; valid in RUN and BR_FIX
- incr_i  in  1  advance PC by instr_len_i
- instr_len_i  in  2  bytes to advance, 1..3; 0 = hold
- jump_i  in  1  load jump_pc_i
- jump_pc_i  in  ADDR_W  absolute target
- branch_i  in  1  taken relative branch
- branch_off_i  in  8  signed two's-complement offset
- vec_req_i  in  1  start a vector load
- vec_sel_i  in  1  0 = NMI, 1 = IRQ/BRK
- mem_req_o  out  1  vector byte read request
- mem_addr_o  out  ADDR_W  vector byte address
- mem_rdata_i  in  8  read data
- mem_ack_i  in  1  read data valid; completes the request
- pc_o  out  ADDR_W  current PC
- pc_valid_o  out  1  pc_o is architecturally valid
- busy_o  out  1  unit not in RUN; redirect inputs ignored
- page_cross_o  out  1  one-cycle pulse on a page-crossing branch

Behaviour:
- Reset: clock is clk_i; reset is asynchronous and active-low on rstn_i.
  - State VEC_LO with vector address = RESET_VEC.
  - pc_o = 0, pc_valid_o = 0, busy_o = 1, page_cross_o = 0, mem_req_o = 1, mem_addr_o = RESET_VEC.
- States: VEC_LO, VEC_HI, RUN, BR_FIX.
- VEC_LO:
  - mem_req_o = 1, mem_addr_o = vector address.
  - On mem_ack_i: latch mem_rdata_i as the low byte, go to VEC_HI.
- VEC_HI:
  - mem_addr_o = vector address + 1, modulo 2^ADDR_W.
  - On mem_ack_i: next cycle pc_o = {mem_rdata_i, lo}, pc_valid_o = 1, state RUN.
- Vector states: mem_req_o stays high until ack. stall_i and all redirect inputs are ignored.
- RUN, one-cycle latency. Evaluated each posedge, highest priority first:
  1. stall_i: hold everything.
  2. vec_req_i: go to VEC_LO with NMI_VEC or IRQ_VEC per vec_sel_i; pc_valid_o drops next cycle; pc_o holds its old value.
  3. jump_i: pc_o = jump_pc_i.
  4. branch_i: sum = pc_o + sign_extend(branch_off_i), modulo 2^ADDR_W.
     - High byte of sum equals that of pc_o: pc_o = sum.
     - Otherwise: pc_o = {pc_o[ADDR_W-1:8], sum[7:0]}, pc_valid_o = 0, page_cross_o = 1 for that cycle, state BR_FIX.
  5. incr_i: pc_o = pc_o + instr_len_i, modulo 2^ADDR_W.
- BR_FIX:
  - Unless stalled: pc_o = stored sum, pc_valid_o = 1, state RUN.
  - page_cross_o = 0.
  - Redirect inputs ignored.
- busy_o = 1 in every state except RUN.
- Wrap-around: FFFF + 1 → 0000 with no flag. Branches across 0000/FFFF follow the page-cross rule.
- Vector/mem_ack_i boundaries:
  - mem_ack_i outside the vector states is ignored.
  - vec_req_i during BR_FIX is ignored; the requester must hold it.
- Reset asserted mid-operation, including a vector fetch: immediate return to reset state; the next fetch uses RESET_VEC.

Decomposition:
- nes_cpu_pkg gains:
  - pc_state_e enum {VEC_LO, VEC_HI, RUN, BR_FIX}
  - constants RESET_VEC_ADDR, NMI_VEC_ADDR, IRQ_VEC_ADDR
  - typedef instr_len_t (2 bits)
- MEM_ADDR_SIZE remains the source of ADDR_W.
- One natural sub-module: pc_branch_calc.
  - Combinational sign-extend, add, and high-byte compare.
  - Outputs sum and page_cross.
  - Reusable by the branch unit.

Test Plan:
1. Reset, ack lo = 0x34 then hi = 0x12 → mem_addr_o FFFC then FFFD; pc_o = 0x1234 and pc_valid_o = 1 one cycle after the second ack.
2. pc = 0x8000; incr with lengths 1, 2, 3; then stall two cycles → 0x8001, 0x8003, 0x8006, held at 0x8006.
3. Branch at 0x80F0 with offset 0x05 → 0x80F5, no page_cross. Branch at 0x80F0 with offset 0x20 → 0x8010 with pc_valid_o = 0 and page_cross_o pulse, then 0x8110 valid.
4. Wrap: pc = 0xFFFF, incr 1 → 0x0000. pc = 0x0010, branch offset 0xE0 → 0x00F0 intermediate, then 0xFFF0.
5. Jump and branch in the same cycle → jump wins. vec_req_i (NMI) together with jump → mem_addr_o = FFFA; acks 0x00, 0xC0 → pc_o = 0xC000.
6. Assert rstn_i low during VEC_HI of an IRQ load → immediate reset state; the next fetch address is FFFC.
